// File: rtl/xge_arb_pkg.sv
// Shared constants and beat payload type for the two-port XGE TX arbiter.
package xge_arb_pkg;

  localparam int unsigned MAX_BEATS_DEF = 1200;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned BE_W          = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT0  = 2'd1;
  localparam logic [1:0] ST_GNT1  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic              last;
    logic              error;
  } beat_t;

endpackage

// File: rtl/xge_rr_pick.sv
// Two-way round-robin pick: when both request, the port not granted last time wins.
module xge_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic pick_valid_c,
  output logic pick_c
);

  always_comb begin
    pick_valid_c = req0 | req1;
    pick_c       = 1'b0;
    if (req0 && req1) begin
      pick_c = ~last_owner;
    end else if (req1) begin
      pick_c = 1'b1;
    end
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Frame-atomic arbiter of two 64-bit beat streams onto one XGE MAC TX port,
// with a jumbo-length guard that aborts and drains over-long frames.
module xge_tx_arbiter
  import xge_arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              tx_mac_clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [63:0]       s0_data,
  input  logic [7:0]        s0_byte,
  input  logic              s0_last,
  input  logic              s0_error,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [63:0]       s1_data,
  input  logic [7:0]        s1_byte,
  input  logic              s1_last,
  input  logic              s1_error,
  output logic              s1_ready,
  output logic              tx_mac_valid,
  output logic [63:0]       tx_mac_data,
  output logic [7:0]        tx_mac_byte,
  output logic              tx_mac_last,
  output logic              tx_mac_error,
  input  logic              tx_mac_ready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int unsigned       BEAT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(MAX_BEATS - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        grant_nxt;
  logic              last_owner;
  logic [BEAT_W-1:0] beat_cnt;

  beat_t s0_beat;
  beat_t s1_beat;
  beat_t sel_beat;
  logic  sel_valid;
  logic  force_abort;
  logic  beat_acc;
  logic  drain_valid;
  logic  drain_last;
  logic  pick_valid_c;
  logic  pick_c;

  assign s0_beat = '{data: s0_data, be: s0_byte, last: s0_last, error: s0_error};
  assign s1_beat = '{data: s1_data, be: s1_byte, last: s1_last, error: s1_error};

  xge_rr_pick u_pick (
    .req0         (s0_valid),
    .req1         (s1_valid),
    .last_owner   (last_owner),
    .pick_valid_c (pick_valid_c),
    .pick_c       (pick_c)
  );

  // Datapath mux, handshake steering and next-state decode.
  always_comb begin
    sel_valid   = 1'b0;
    sel_beat    = '0;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    drain_valid = last_owner ? s1_valid : s0_valid;
    drain_last  = last_owner ? s1_last  : s0_last;
    state_nxt   = state;

    case (state)
      ST_GNT0: begin
        sel_valid = s0_valid;
        sel_beat  = s0_beat;
        s0_ready  = tx_mac_ready;
      end
      ST_GNT1: begin
        sel_valid = s1_valid;
        sel_beat  = s1_beat;
        s1_ready  = tx_mac_ready;
      end
      ST_DRAIN: begin
        s0_ready = ~last_owner;
        s1_ready = last_owner;
      end
      default: ;
    endcase

    beat_acc    = sel_valid && tx_mac_ready;
    force_abort = sel_valid && !sel_beat.last && (beat_cnt == LAST_IDX);

    case (state)
      ST_IDLE: begin
        if (pick_valid_c) state_nxt = pick_c ? ST_GNT1 : ST_GNT0;
      end
      ST_GNT0, ST_GNT1: begin
        if (beat_acc) begin
          if (sel_beat.last)    state_nxt = ST_IDLE;
          else if (force_abort) state_nxt = ST_DRAIN;
        end
      end
      default: begin
        if (drain_valid && drain_last) state_nxt = ST_IDLE;
      end
    endcase

    case (state_nxt)
      ST_GNT0: grant_nxt = 2'b01;
      ST_GNT1: grant_nxt = 2'b10;
      ST_IDLE: grant_nxt = 2'b00;
      default: grant_nxt = grant;
    endcase

    tx_mac_valid = sel_valid;
    tx_mac_data  = sel_beat.data;
    tx_mac_byte  = sel_beat.be;
    tx_mac_last  = sel_beat.last  | force_abort;
    tx_mac_error = sel_beat.error | force_abort;
  end

  // State, ownership history, beat length and statistics.
  always_ff @(posedge tx_mac_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      abort_cnt  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == ST_IDLE && pick_valid_c) begin
        last_owner <= pick_c;
        beat_cnt   <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
      if (beat_acc && sel_beat.last) begin
        if (state == ST_GNT1) frame_cnt1 <= frame_cnt1 + CNT_W'(1);
        else                  frame_cnt0 <= frame_cnt0 + CNT_W'(1);
      end
      if (beat_acc && force_abort) begin
        abort_cnt <= abort_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed bench for xge_tx_arbiter: per-cycle vector table plus reset and wrap sequences.
module tb_xge_tx_arbiter;

  localparam int unsigned TB_MAX_BEATS = 8;
  // Narrow counters so the statistics wrap is reached in a few hundred cycles.
  localparam int unsigned TB_CNT_W     = 8;

  typedef struct {
    logic       pre_rst;
    logic       v0, l0, v1, l1, rdy;
    logic [7:0] tag;
    logic       tv, tl, te;
    logic [1:0] src, gnt;
    logic       r0, r1;
    int         fc0, fc1, ac;
  } row_t;

  logic                tx_mac_clk = 1'b0;
  logic                rst;
  logic                s0_valid, s0_last, s0_error, s0_ready;
  logic                s1_valid, s1_last, s1_error, s1_ready;
  logic [63:0]         s0_data, s1_data;
  logic [7:0]          s0_byte, s1_byte;
  logic                tx_mac_valid, tx_mac_last, tx_mac_error, tx_mac_ready;
  logic [63:0]         tx_mac_data;
  logic [7:0]          tx_mac_byte;
  logic [1:0]          grant;
  logic [TB_CNT_W-1:0] frame_cnt0, frame_cnt1, abort_cnt;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  row_t vec[$];

  always #5 tx_mac_clk = ~tx_mac_clk;

  xge_tx_arbiter #(.MAX_BEATS(TB_MAX_BEATS), .CNT_W(TB_CNT_W)) dut (
    .tx_mac_clk   (tx_mac_clk),
    .rst          (rst),
    .s0_valid     (s0_valid),
    .s0_data      (s0_data),
    .s0_byte      (s0_byte),
    .s0_last      (s0_last),
    .s0_error     (s0_error),
    .s0_ready     (s0_ready),
    .s1_valid     (s1_valid),
    .s1_data      (s1_data),
    .s1_byte      (s1_byte),
    .s1_last      (s1_last),
    .s1_error     (s1_error),
    .s1_ready     (s1_ready),
    .tx_mac_valid (tx_mac_valid),
    .tx_mac_data  (tx_mac_data),
    .tx_mac_byte  (tx_mac_byte),
    .tx_mac_last  (tx_mac_last),
    .tx_mac_error (tx_mac_error),
    .tx_mac_ready (tx_mac_ready),
    .grant        (grant),
    .frame_cnt0   (frame_cnt0),
    .frame_cnt1   (frame_cnt1),
    .abort_cnt    (abort_cnt)
  );

  function automatic logic [63:0] s0_dat(input logic [7:0] t);
    return 64'h5a5a_0000_0000_0000 | {56'h0, t};
  endfunction

  function automatic logic [63:0] s1_dat(input logic [7:0] t);
    return 64'ha5a5_0000_0000_0000 | {56'h0, t};
  endfunction

  function automatic row_t mk(input int rs, input int v0, input int l0, input int v1,
                              input int l1, input int rdy, input int tag,
                              input int tv, input int tl, input int te, input int src,
                              input int gnt, input int r0, input int r1,
                              input int fc0, input int fc1, input int ac);
    row_t r;
    r.pre_rst = 1'(rs);  r.v0 = 1'(v0); r.l0 = 1'(l0); r.v1 = 1'(v1); r.l1 = 1'(l1);
    r.rdy = 1'(rdy);     r.tag = 8'(tag);
    r.tv = 1'(tv);       r.tl = 1'(tl); r.te = 1'(te);
    r.src = 2'(src);     r.gnt = 2'(gnt); r.r0 = 1'(r0); r.r1 = 1'(r1);
    r.fc0 = fc0;         r.fc1 = fc1;     r.ac = ac;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    s0_valid = r.v0; s0_last = r.l0; s0_data = s0_dat(r.tag); s0_byte = r.tag;  s0_error = 1'b0;
    s1_valid = r.v1; s1_last = r.l1; s1_data = s1_dat(r.tag); s1_byte = ~r.tag; s1_error = 1'b0;
    tx_mac_ready = r.rdy;
  endtask

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0; s0_byte = '0; s0_error = 1'b0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0; s1_byte = '0; s1_error = 1'b0;
    tx_mac_ready = 1'b1;
  endtask

  initial begin
    row_t        r;
    logic [63:0] exp_data;
    logic [7:0]  exp_byte;
    int          acc;
    int          cyc;

    rst = 1'b1;
    idle_inputs();

    // s0 three-beat frame out of reset
    vec.push_back(mk(1, 1,0,0,0,1,1, 0,0,0,0,0,0,0, 0,0,0));
    vec.push_back(mk(0, 1,0,0,0,1,1, 1,0,0,1,1,1,0, 0,0,0));
    vec.push_back(mk(0, 1,0,0,0,1,2, 1,0,0,1,1,1,0, 0,0,0));
    vec.push_back(mk(0, 1,1,0,0,1,3, 1,1,0,1,1,1,0, 0,0,0));
    vec.push_back(mk(0, 0,0,0,0,1,0, 0,0,0,0,0,0,0, 1,0,0));
    // both ports contend from reset, two-beat frames, alternate s0,s1,s0,s1
    vec.push_back(mk(1, 1,0,1,0,1,1, 0,0,0,0,0,0,0, 0,0,0));
    vec.push_back(mk(0, 1,0,1,0,1,1, 1,0,0,1,1,1,0, 0,0,0));
    vec.push_back(mk(0, 1,1,1,0,1,2, 1,1,0,1,1,1,0, 0,0,0));
    vec.push_back(mk(0, 1,0,1,0,1,3, 0,0,0,0,0,0,0, 1,0,0));
    vec.push_back(mk(0, 1,0,1,0,1,3, 1,0,0,2,2,0,1, 1,0,0));
    vec.push_back(mk(0, 1,0,1,1,1,4, 1,1,0,2,2,0,1, 1,0,0));
    vec.push_back(mk(0, 1,0,1,0,1,5, 0,0,0,0,0,0,0, 1,1,0));
    vec.push_back(mk(0, 1,0,1,0,1,5, 1,0,0,1,1,1,0, 1,1,0));
    vec.push_back(mk(0, 1,1,1,0,1,6, 1,1,0,1,1,1,0, 1,1,0));
    vec.push_back(mk(0, 1,0,1,0,1,7, 0,0,0,0,0,0,0, 2,1,0));
    vec.push_back(mk(0, 1,0,1,0,1,7, 1,0,0,2,2,0,1, 2,1,0));
    vec.push_back(mk(0, 1,0,1,1,1,8, 1,1,0,2,2,0,1, 2,1,0));
    vec.push_back(mk(0, 0,0,0,0,1,0, 0,0,0,0,0,0,0, 2,2,0));
    // s1 ten-beat frame: forced abort on beat 8, beats 9-10 drained
    vec.push_back(mk(0, 0,0,1,0,1,1, 0,0,0,0,0,0,0, 2,2,0));
    for (int k = 1; k <= 7; k++)
      vec.push_back(mk(0, 0,0,1,0,1,k, 1,0,0,2,2,0,1, 2,2,0));
    vec.push_back(mk(0, 0,0,1,0,1,8,  1,1,1,2,2,0,1, 2,2,0));
    vec.push_back(mk(0, 0,0,1,0,1,9,  0,0,0,0,2,0,1, 2,2,1));
    vec.push_back(mk(0, 0,0,1,1,1,10, 0,0,0,0,2,0,1, 2,2,1));
    vec.push_back(mk(0, 0,0,0,0,1,0,  0,0,0,0,0,0,0, 2,2,1));
    // s0 four-beat frame with tx_mac_ready toggling
    vec.push_back(mk(0, 1,0,0,0,1,1, 0,0,0,0,0,0,0, 2,2,1));
    vec.push_back(mk(0, 1,0,0,0,1,1, 1,0,0,1,1,1,0, 2,2,1));
    vec.push_back(mk(0, 1,0,0,0,0,2, 1,0,0,1,1,0,0, 2,2,1));
    vec.push_back(mk(0, 1,0,0,0,1,2, 1,0,0,1,1,1,0, 2,2,1));
    vec.push_back(mk(0, 1,0,0,0,0,3, 1,0,0,1,1,0,0, 2,2,1));
    vec.push_back(mk(0, 1,0,0,0,1,3, 1,0,0,1,1,1,0, 2,2,1));
    vec.push_back(mk(0, 1,1,0,0,0,4, 1,1,0,1,1,0,0, 2,2,1));
    vec.push_back(mk(0, 1,1,0,0,1,4, 1,1,0,1,1,1,0, 2,2,1));
    vec.push_back(mk(0, 0,0,0,0,1,0, 0,0,0,0,0,0,0, 3,2,1));
    // s0 frame of exactly MAX_BEATS with last, plus a valid gap: normal completion
    vec.push_back(mk(0, 1,0,0,0,1,1, 0,0,0,0,0,0,0, 3,2,1));
    for (int k = 1; k <= 3; k++)
      vec.push_back(mk(0, 1,0,0,0,1,k, 1,0,0,1,1,1,0, 3,2,1));
    vec.push_back(mk(0, 0,0,0,0,1,9, 0,0,0,1,1,1,0, 3,2,1));
    for (int k = 4; k <= 7; k++)
      vec.push_back(mk(0, 1,0,0,0,1,k, 1,0,0,1,1,1,0, 3,2,1));
    vec.push_back(mk(0, 1,1,0,0,1,8, 1,1,0,1,1,1,0, 3,2,1));
    vec.push_back(mk(0, 0,0,0,0,1,0, 0,0,0,0,0,0,0, 4,2,1));

    for (int i = 0; i < vec.size(); i++) begin
      r = vec[i];
      @(negedge tx_mac_clk);
      if (r.pre_rst) begin
        rst = 1'b1;
        idle_inputs();
        @(negedge tx_mac_clk);
        rst = 1'b0;
      end
      drive(r);
      #1;
      exp_data = (r.src == 2'd1) ? s0_dat(r.tag) : (r.src == 2'd2) ? s1_dat(r.tag) : 64'h0;
      exp_byte = (r.src == 2'd1) ? r.tag : (r.src == 2'd2) ? ~r.tag : 8'h0;
      chk("tx_valid", i, 64'(tx_mac_valid), 64'(r.tv));
      chk("tx_last",  i, 64'(tx_mac_last),  64'(r.tl));
      chk("tx_error", i, 64'(tx_mac_error), 64'(r.te));
      chk("tx_data",  i, tx_mac_data,       exp_data);
      chk("tx_byte",  i, 64'(tx_mac_byte),  64'(exp_byte));
      chk("grant",    i, 64'(grant),        64'(r.gnt));
      chk("s0_ready", i, 64'(s0_ready),     64'(r.r0));
      chk("s1_ready", i, 64'(s1_ready),     64'(r.r1));
      chk("frame_cnt0", i, 64'(frame_cnt0), 64'(r.fc0));
      chk("frame_cnt1", i, 64'(frame_cnt1), 64'(r.fc1));
      chk("abort_cnt",  i, 64'(abort_cnt),  64'(r.ac));
      if (tx_mac_valid && tx_mac_ready) xfers++;
    end
    chk("mac_transfers", 0, 64'(xfers), 64'd31);

    // reset pulsed while beat 2 of an s0 frame is on the bus
    @(negedge tx_mac_clk);
    idle_inputs();
    s0_valid = 1'b1; s0_data = s0_dat(8'h21); s0_byte = 8'h21;
    #1 chk("rst_pre_idle", 0, 64'(tx_mac_valid), 64'd0);
    @(negedge tx_mac_clk);
    #1 chk("rst_beat1_grant", 0, 64'(grant), 64'd1);
    @(negedge tx_mac_clk);
    s0_data = s0_dat(8'h22); s0_byte = 8'h22; rst = 1'b1;
    #1 chk("rst_beat2_data", 0, tx_mac_data, s0_dat(8'h22));
    @(negedge tx_mac_clk);
    rst = 1'b0; s0_valid = 1'b0;
    s1_valid = 1'b1; s1_last = 1'b1; s1_data = s1_dat(8'h33); s1_byte = 8'hcc;
    #1;
    chk("rst_tx_valid", 0, 64'(tx_mac_valid), 64'd0);
    chk("rst_tx_last",  0, 64'(tx_mac_last),  64'd0);
    chk("rst_grant",    0, 64'(grant),        64'd0);
    chk("rst_fc0",      0, 64'(frame_cnt0),   64'd0);
    chk("rst_fc1",      0, 64'(frame_cnt1),   64'd0);
    chk("rst_abort",    0, 64'(abort_cnt),    64'd0);
    @(negedge tx_mac_clk);
    #1;
    chk("post_rst_grant", 0, 64'(grant),        64'd2);
    chk("post_rst_data",  0, tx_mac_data,       s1_dat(8'h33));
    chk("post_rst_last",  0, 64'(tx_mac_last),  64'd1);
    chk("post_rst_ready", 0, 64'(s1_ready),     64'd1);
    @(negedge tx_mac_clk);
    s1_valid = 1'b0; s1_last = 1'b0;
    #1;
    chk("post_rst_idle", 0, 64'(grant),      64'd0);
    chk("post_rst_fc1",  0, 64'(frame_cnt1), 64'd1);

    // back-to-back one-beat s0 frames until frame_cnt0 wraps
    s0_valid = 1'b1; s0_last = 1'b1; s0_data = s0_dat(8'h77); s0_byte = 8'h77;
    tx_mac_ready = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < (1 << TB_CNT_W) && cyc < 4000) begin
      @(negedge tx_mac_clk);
      #1;
      cyc++;
      if (tx_mac_valid && tx_mac_ready) begin
        acc++;
        if (acc == (1 << TB_CNT_W)) chk("fc0_before_wrap", acc, 64'(frame_cnt0), 64'd255);
      end
    end
    chk("wrap_budget", cyc, 64'(acc), 64'(1 << TB_CNT_W));
    @(negedge tx_mac_clk);
    s0_valid = 1'b0; s0_last = 1'b0;
    #1;
    chk("fc0_wrapped", 0, 64'(frame_cnt0), 64'd0);
    chk("fc1_after_wrap", 0, 64'(frame_cnt1), 64'd1);
    chk("abort_after_wrap", 0, 64'(abort_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xge_tx_arbiter.md
XGE_TX_ARBITER -- requirements
Module: xge_tx_arbiter

Interface
REQ-001 Parameter: MAX_BEATS, 1200, maximum accepted beats per frame (9600-byte jumbo / 8) before forced abort.
REQ-002 Parameter: CNT_W, 16, width of the statistics counters.
REQ-003 Port: tx_mac_clk  in  1  MAC TX user clock; sole clock.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Ports s0_valid/s1_valid  in  1 each  requester beat valid.
REQ-006 Ports s0_data/s1_data  in  64; s0_byte/s1_byte  in  8 (byte-valid mask); s0_last/s1_last, s0_error/s1_error  in  1.
REQ-007 Ports s0_ready/s1_ready  out  1  requester beat accepted when valid&&ready.
REQ-008 Ports tx_mac_valid  out  1; tx_mac_data  out  64; tx_mac_byte  out  8; tx_mac_last, tx_mac_error  out  1; tx_mac_ready  in  1.
REQ-009 Port: grant  out  2  one-hot current owner, 2'b00 when none.
REQ-010 Ports frame_cnt0, frame_cnt1, abort_cnt  out  CNT_W  completed frames per port, forced aborts.

Function
REQ-011 States: IDLE, GNT0, GNT1, DRAIN; the state register, grant and counters are registered; datapath mux is combinational (zero latency, GNTx).
REQ-012 IDLE: all readies 0, tx_mac_valid 0, tx_mac_data/byte 0, last/error 0.
REQ-013 IDLE with only sX_valid=1 -> GNTX next cycle.
REQ-014 IDLE with both valid -> grant the port not most recently granted; last_owner resets to 1 so port 0 wins first.
REQ-015 GNTX: tx_mac_{valid,data,byte,last,error} = sX_*, sX_ready = tx_mac_ready, other port ready 0.
REQ-016 Beat counter clears on entering GNTX and increments on each beat with tx_mac_valid&&tx_mac_ready.
REQ-017 Accepted beat with sX_last=1 -> IDLE next cycle, frame_cntX += 1 (wraps mod 2^CNT_W).
REQ-018 Accepted beat that is the MAX_BEATS-th with sX_last=0 -> tx_mac_last and tx_mac_error forced 1 that beat, abort_cnt += 1, -> DRAIN.
REQ-019 Accepted MAX_BEATS-th beat with sX_last=1 is a normal completion (REQ-017), not an abort.
REQ-020 DRAIN: tx_mac_valid 0, sX_ready 1, other port ready 0; beats discarded; sX_valid&&sX_last -> IDLE; frame_cntX unchanged.
REQ-021 Ownership changes only in IDLE; a frame is never interleaved with the other port.
REQ-022 tx_mac_ready low in GNTX holds the beat; sX_valid low inserts gaps without losing ownership.
REQ-023 At least one IDLE cycle separates consecutive frames.
REQ-024 Counters saturate never; they wrap.

Reset
REQ-025 rst=1 at a clock edge -> next cycle: state IDLE, grant 0, last_owner 1, beat counter 0, all statistics counters 0, all outputs per REQ-012.
REQ-026 Reset mid-frame truncates it: tx_mac_valid drops with no forced last; no counter update.

Structure
REQ-027 Shared package xge_arb_pkg holds the state enum, default MAX_BEATS and CNT_W constants.
REQ-028 One sub-module xge_rr_pick (2-way round-robin pick from valids and last_owner) is natural; counters and muxes stay inline.

Verification (MAX_BEATS=8 in bench)
REQ-029 s0 sends 3-beat frame, tx_mac_ready=1 -> 3 beats on MAC identical to s0, last on beat 3, frame_cnt0=1, grant=01 then 00.
REQ-030 s0 and s1 both valid from reset, 2-beat frames each, repeated twice -> order s0,s1,s0,s1, no interleave, frame_cnt0=frame_cnt1=2.
REQ-031 s1 10-beat frame, no last before beat 10 -> beat 8 output last=1 error=1, beats 9-10 absorbed with tx_mac_valid=0, abort_cnt=1, frame_cnt1=0.
REQ-032 s0 4-beat frame, tx_mac_ready toggles 1,0,1,0 -> each beat held until accepted, data unchanged, exactly 4 transfers.
REQ-033 rst pulsed during beat 2 of s0 frame -> next cycle tx_mac_valid=0, grant=0, all counters 0; following s1 frame granted normally.
REQ-034 frame_cnt0 preloaded path: 65536 one-beat s0 frames -> frame_cnt0 wraps to 0.
